// File: rtl/pe_seq_pkg.sv
// Shared types and constants for the PE drive sequencer.
// Data is Q8.8 signed; the sequencer itself never does arithmetic on it.
package pe_seq_pkg;

  localparam int unsigned FRAC_BITS      = 8;
  localparam int unsigned DATA_WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSwitch,
    StSettle,
    StStream,
    StDrain
  } seq_state_t;

  typedef struct packed {
    logic [DATA_WIDTH_DEF-1:0] data;
    logic                      last;
  } res_t;

endpackage

// File: rtl/pe_drive_seq_if.sv
// Command / activation / result streams plus the PE drive wires of the sequencer.
// slave is the sequencer's view; master is the surrounding controller, buffer and PE.
interface pe_drive_seq_if
  import pe_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned COUNT_W    = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [DATA_WIDTH-1:0] cmd_weight;
  logic [COUNT_W-1:0]    cmd_len;

  logic                  act_valid;
  logic                  act_ready;
  logic [DATA_WIDTH-1:0] act_data;
  logic [DATA_WIDTH-1:0] act_psum;

  logic                  res_valid;
  logic                  res_ready;
  logic [DATA_WIDTH-1:0] res_data;
  logic                  res_last;

  logic [DATA_WIDTH-1:0] drv_weight;
  logic                  drv_accept_w;
  logic                  drv_switch;
  logic [DATA_WIDTH-1:0] drv_input;
  logic [DATA_WIDTH-1:0] drv_psum;
  logic                  drv_valid;
  logic                  drv_enabled;
  logic [DATA_WIDTH-1:0] pe_psum_out;

  modport master (
    output cmd_valid, cmd_weight, cmd_len,
    input  cmd_ready,
    output act_valid, act_data, act_psum,
    input  act_ready,
    input  res_valid, res_data, res_last,
    output res_ready,
    input  drv_weight, drv_accept_w, drv_switch, drv_input, drv_psum, drv_valid, drv_enabled,
    output pe_psum_out
  );

  modport slave (
    input  cmd_valid, cmd_weight, cmd_len,
    output cmd_ready,
    input  act_valid, act_data, act_psum,
    output act_ready,
    output res_valid, res_data, res_last,
    input  res_ready,
    output drv_weight, drv_accept_w, drv_switch, drv_input, drv_psum, drv_valid, drv_enabled,
    input  pe_psum_out
  );
endinterface

// File: rtl/pe_res_fifo.sv
// Synchronous show-ahead FIFO; the occupancy count feeds the sequencer's credit check.
// Read data is forced to zero while empty so the output bus is clean after reset.
module pe_res_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PtrW'(1);
  endfunction

  assign do_push = push && (32'(count_q) != DEPTH);
  assign do_pop  = pop && (count_q != '0);
  assign valid   = (count_q != '0);
  assign rdata   = valid ? mem_q[rd_ptr_q] : '0;
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CntW'(1);
    end
  end

endmodule

// File: rtl/pe_drive_seq.sv
// Drives one systolic PE through weight load, switch and a MAC stream, and queues the
// PE's psum outputs on a ready/valid result stream with credit-based flow control.
module pe_drive_seq
  import pe_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned COUNT_W    = 8,
  parameter int unsigned PE_LAT     = 2,
  parameter int unsigned RES_DEPTH  = 4
) (
  input logic         clk,
  input logic         rst_n,
  pe_drive_seq_if.slave bus
);
  localparam int unsigned CntW = $clog2(RES_DEPTH + 1);

  seq_state_t            state_q, state_d;
  logic [COUNT_W-1:0]    len_q, issued_q;
  logic [PE_LAT-1:0]     vld_sr_q, last_sr_q;
  logic [DATA_WIDTH-1:0] drv_weight_q, drv_input_q, drv_psum_q;
  logic                  drv_accept_w_q, drv_switch_q, drv_valid_q, enabled_q;

  logic                  cmd_ready, act_ready, cmd_hs, act_hs, last_op;
  logic                  fifo_valid;
  logic [DATA_WIDTH:0]   fifo_rdata;
  logic [CntW-1:0]       fifo_count;
  int unsigned           inflight, credit_used;

  always_comb begin
    inflight    = $countones(vld_sr_q);
    credit_used = inflight + 32'(fifo_count);
    // enabled_q doubles as "out of reset" so cmd_ready stays low while rst_n is asserted
    cmd_ready   = (state_q == StIdle) && enabled_q;
    act_ready   = (state_q == StStream) && (issued_q < len_q) && (credit_used < RES_DEPTH);
    state_d     = state_q;
    unique case (state_q)
      StIdle:   if (cmd_hs) state_d = StLoad;
      StLoad:   state_d = StSwitch;
      StSwitch: state_d = StSettle;
      StSettle: state_d = (len_q == '0) ? StIdle : StStream;
      StStream: if (issued_q == len_q) state_d = StDrain;
      StDrain:  if (inflight == 0) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  assign cmd_hs  = bus.cmd_valid && cmd_ready;
  assign act_hs  = bus.act_valid && act_ready;
  assign last_op = (issued_q + COUNT_W'(1)) == len_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      len_q          <= '0;
      issued_q       <= '0;
      vld_sr_q       <= '0;
      last_sr_q      <= '0;
      drv_weight_q   <= '0;
      drv_input_q    <= '0;
      drv_psum_q     <= '0;
      drv_accept_w_q <= 1'b0;
      drv_switch_q   <= 1'b0;
      drv_valid_q    <= 1'b0;
      enabled_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      enabled_q <= 1'b1;
      if (cmd_hs) begin
        len_q    <= bus.cmd_len;
        issued_q <= '0;
      end else if (act_hs) begin
        issued_q <= issued_q + COUNT_W'(1);
      end
      drv_accept_w_q <= cmd_hs;
      drv_weight_q   <= cmd_hs ? bus.cmd_weight : '0;
      drv_switch_q   <= (state_q == StLoad);
      drv_valid_q    <= act_hs;
      drv_input_q    <= act_hs ? bus.act_data : '0;
      drv_psum_q     <= act_hs ? bus.act_psum : '0;
      // Tail bit of vld_sr_q marks the edge where pe_psum_out holds that op's result
      vld_sr_q       <= (vld_sr_q << 1) | PE_LAT'(act_hs);
      last_sr_q      <= (last_sr_q << 1) | PE_LAT'(act_hs && last_op);
    end
  end

  pe_res_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (vld_sr_q[PE_LAT-1]),
    .wdata ({bus.pe_psum_out, last_sr_q[PE_LAT-1]}),
    .pop   (fifo_valid && bus.res_ready),
    .rdata (fifo_rdata),
    .valid (fifo_valid),
    .count (fifo_count)
  );

  assign bus.cmd_ready    = cmd_ready;
  assign bus.act_ready    = act_ready;
  assign bus.res_valid    = fifo_valid;
  assign bus.res_data     = fifo_rdata[DATA_WIDTH:1];
  assign bus.res_last     = fifo_rdata[0];
  assign bus.drv_weight   = drv_weight_q;
  assign bus.drv_accept_w = drv_accept_w_q;
  assign bus.drv_switch   = drv_switch_q;
  assign bus.drv_input    = drv_input_q;
  assign bus.drv_psum     = drv_psum_q;
  assign bus.drv_valid    = drv_valid_q;
  assign bus.drv_enabled  = enabled_q;

endmodule
